imem_loader: RTL and testbench

//  Write side of the instruction memory that the fetch stage reads. Accepts a byte stream
//  (valid/ready, e.g. from the UART debug path) and packs it into 32-bit words. Writes each

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader_word_packer.sv | 33 +++
 rtl/imem_loader.sv | 102 ++++++++++
 tb/tb_imem_loader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants and loader state encoding for the instruction-memory write path.
// instr_mem and imem_loader both take their defaults from here.
package imem_loader_pkg;

    localparam int          IMEM_ADDR_WIDTH = 8;
    localparam logic [31:0] IMEM_HALT_WORD  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        LDR_IDLE  = 2'd0,
        LDR_RECV  = 2'd1,
        LDR_WRITE = 2'd2,
        LDR_DONE  = 2'd3
    } ldr_state_e;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs four accepted bytes big-endian into one word. word is combinational so the
// completed word, including the byte being accepted now, is available in the same cycle.
module imem_loader_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_idx;
    logic [23:0] lead_bytes;

    assign word_valid = byte_en && (byte_idx == 2'd3);
    assign word       = {lead_bytes, byte_in};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx   <= 2'd0;
            lead_bytes <= 24'd0;
        end else if (clear) begin
            byte_idx   <= 2'd0;
            lead_bytes <= 24'd0;
        end else if (byte_en) begin
            // The index wraps from 3 to 0 as the fourth byte completes the word.
            lead_bytes <= {lead_bytes[15:0], byte_in};
            byte_idx   <= byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory as big-endian words from address 0 and
// keeps the CPU held until the halt word is written or the memory is full.
// Handshake: a byte transfers on a rising edge where i_byte_valid && o_byte_ready.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter logic [31:0] HALT_WORD  = IMEM_HALT_WORD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic                  i_byte_valid,
    input  logic [7:0]            i_byte,
    output logic                  o_byte_ready,
    output logic                  o_imem_we,
    output logic [31:0]           o_imem_addr,
    output logic [31:0]           o_imem_wdata,
    output logic                  o_cpu_hold,
    output logic                  o_load_done,
    output logic                  o_overflow,
    output logic [ADDR_WIDTH:0]   o_word_count,
    output ldr_state_e            o_state
);

    localparam int unsigned        CAPACITY = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(CAPACITY - 1);

    ldr_state_e  state, state_n;
    logic        start_ok, byte_take, word_valid, halt_hit, full_hit;
    logic [31:0] packed_word;

    // i_start has no effect while a word is being written.
    assign start_ok  = i_start && (state != LDR_WRITE);
    assign byte_take = i_byte_valid && o_byte_ready && !i_start;
    assign halt_hit  = (o_imem_wdata == HALT_WORD);
    assign full_hit  = (o_word_count == LAST_IDX);
    assign o_state   = state;

    imem_loader_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .byte_en    (byte_take),
        .byte_in    (i_byte),
        .word_valid (word_valid),
        .word       (packed_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LDR_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            LDR_IDLE:  if (i_start) state_n = LDR_RECV;
            LDR_RECV:  begin
                if (i_start)         state_n = LDR_RECV;
                else if (word_valid) state_n = LDR_WRITE;
            end
            LDR_WRITE: begin
                if (halt_hit || full_hit) state_n = LDR_DONE;
                else                      state_n = LDR_RECV;
            end
            LDR_DONE:  if (i_start) state_n = LDR_RECV;
            default:   state_n = LDR_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_byte_ready <= 1'b0;
            o_imem_we    <= 1'b0;
            o_imem_addr  <= 32'd0;
            o_imem_wdata <= 32'd0;
            o_cpu_hold   <= 1'b1;
            o_load_done  <= 1'b0;
            o_overflow   <= 1'b0;
            o_word_count <= '0;
        end else begin
            o_byte_ready <= (state_n == LDR_RECV);
            o_imem_we    <= (state_n == LDR_WRITE);
            o_cpu_hold   <= (state_n != LDR_DONE);
            o_load_done  <= (state_n == LDR_DONE);
            if (state_n == LDR_WRITE) begin
                o_imem_addr  <= 32'({o_word_count[ADDR_WIDTH-1:0], 2'b00});
                o_imem_wdata <= packed_word;
            end
            if (start_ok) begin
                o_word_count <= '0;
                o_overflow   <= 1'b0;
            end else if (state == LDR_WRITE) begin
                o_word_count <= o_word_count + 1'b1;
                if (!halt_hit && full_hit) o_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a full-size and a 4-word instance, a transaction-level model of
// accepted bytes -> expected writes, and directed plus randomized loads.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam logic [31:0] HALT = IMEM_HALT_WORD;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start  [2];
    logic        bvalid [2];
    logic [7:0]  bdata  [2];
    logic        ready  [2];
    logic        we     [2];
    logic        hold   [2];
    logic        done   [2];
    logic        ovf    [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    ldr_state_e  st     [2];
    logic [8:0]  cnt0;
    logic [2:0]  cnt1;

    imem_loader #(.ADDR_WIDTH(8)) u_big (
        .clk(clk), .reset(reset), .i_start(start[0]), .i_byte_valid(bvalid[0]),
        .i_byte(bdata[0]), .o_byte_ready(ready[0]), .o_imem_we(we[0]),
        .o_imem_addr(addr[0]), .o_imem_wdata(wdata[0]), .o_cpu_hold(hold[0]),
        .o_load_done(done[0]), .o_overflow(ovf[0]), .o_word_count(cnt0), .o_state(st[0])
    );

    imem_loader #(.ADDR_WIDTH(2)) u_small (
        .clk(clk), .reset(reset), .i_start(start[1]), .i_byte_valid(bvalid[1]),
        .i_byte(bdata[1]), .o_byte_ready(ready[1]), .o_imem_we(we[1]),
        .o_imem_addr(addr[1]), .o_imem_wdata(wdata[1]), .o_cpu_hold(hold[1]),
        .o_load_done(done[1]), .o_overflow(ovf[1]), .o_word_count(cnt1), .o_state(st[1])
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int count_of(input int k);
        return (k == 0) ? int'(cnt0) : int'(cnt1);
    endfunction

    function automatic int cap_of(input int k);
        return (k == 0) ? 256 : 4;
    endfunction

    // ---------------- reference model / scoreboard ----------------
    // Every accepted byte is appended to a word; each complete word becomes one expected
    // write {instance, byte address, data}, expected one cycle after its last byte.
    int          nb        [2];
    int          words     [2];
    logic [31:0] acc       [2];
    bit          active    [2];
    bit          stopped   [2];
    bit          halt_seen [2];
    logic [64:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [64:0] mon_e;
    int          mon_c;

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                nb[k] = 0; words[k] = 0; active[k] = 0; stopped[k] = 0; halt_seen[k] = 0;
            end
            exp_q.delete();
            exp_cyc_q.delete();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (active[k] && !stopped[k]) check($sformatf("hold_busy%0d", k), 64'(hold[k]), 64'd1);
                if (we[k]) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("wr_unexpected%0d", k), 64'd1, 64'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        mon_c = exp_cyc_q.pop_front();
                        check("wr_inst", 64'(k), 64'(mon_e[64]));
                        check("wr_addr", 64'(addr[k]), 64'(mon_e[63:32]));
                        check("wr_data", 64'(wdata[k]), 64'(mon_e[31:0]));
                        check("wr_latency", 64'(cyc), 64'(mon_c + 1));
                    end
                end
                if (start[k] && !we[k]) begin
                    active[k] = 1; stopped[k] = 0; halt_seen[k] = 0; nb[k] = 0; words[k] = 0;
                end else if (bvalid[k] && ready[k]) begin
                    acc[k] = {acc[k][23:0], bdata[k]};
                    nb[k]++;
                    if (nb[k] == 4) begin
                        exp_q.push_back({1'(k), 32'(words[k] * 4), acc[k]});
                        exp_cyc_q.push_back(cyc);
                        words[k]++;
                        nb[k] = 0;
                        if (acc[k] == HALT) halt_seen[k] = 1;
                        if (halt_seen[k] || words[k] == cap_of(k)) stopped[k] = 1;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks (inputs change 1 time unit after posedge) ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int k);
        start[k] = 1'b1;
        idle(1);
        start[k] = 1'b0;
    endtask

    task automatic send_byte(input int k, input logic [7:0] b);
        int n;
        bit ok;
        n  = 0;
        ok = 0;
        bdata[k]  = b;
        bvalid[k] = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = ready[k];
            @(posedge clk);
            #1;
            n++;
        end
        bvalid[k] = 1'b0;
        bdata[k]  = $urandom_range(0, 255);
        if (!ok) check("byte_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_word(input int k, input logic [31:0] w, input int gmin, input int gmax);
        logic [31:0] wv;
        wv = w;
        for (int i = 0; i < 4; i++) begin
            idle($urandom_range(gmin, gmax));
            send_byte(k, wv[31 - 8*i -: 8]);
        end
    endtask

    // Settled status against the model.
    task automatic settle_check(input int k);
        idle(3);
        @(negedge clk);
        check($sformatf("queue_empty%0d", k), 64'(exp_q.size()), 64'd0);
        check($sformatf("count%0d", k), 64'(count_of(k)), 64'(words[k]));
        check($sformatf("done%0d", k), 64'(done[k]), 64'(stopped[k]));
        check($sformatf("overflow%0d", k), 64'(ovf[k]), 64'(stopped[k] && !halt_seen[k]));
        check($sformatf("hold%0d", k), 64'(hold[k]), 64'(!stopped[k]));
        check($sformatf("ready%0d", k), 64'(ready[k]), 64'(active[k] && !stopped[k]));
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_we", 64'(we[k]), 64'd0);
            check("rst_ready", 64'(ready[k]), 64'd0);
            check("rst_count", 64'(count_of(k)), 64'd0);
            check("rst_hold", 64'(hold[k]), 64'd1);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] w;
        int          k;
        int          nw;

        // 1: reset held with random inputs
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 2; j++) begin
                start[j]  = 1'($urandom_range(0, 1));
                bvalid[j] = 1'($urandom_range(0, 1));
                bdata[j]  = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                check("reset_hold", 64'(hold[j]), 64'd1);
                check("reset_ready", 64'(ready[j]), 64'd0);
                check("reset_we", 64'(we[j]), 64'd0);
                check("reset_done", 64'(done[j]), 64'd0);
                check("reset_ovf", 64'(ovf[j]), 64'd0);
                check("reset_count", 64'(count_of(j)), 64'd0);
            end
        end
        for (int j = 0; j < 2; j++) begin
            start[j] = 1'b0; bvalid[j] = 1'b0; bdata[j] = 8'd0;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(5);
        @(negedge clk);
        check("idle_state", 64'(st[0]), 64'(LDR_IDLE));
        check("idle_ready", 64'(ready[0]), 64'd0);
        check("idle_hold", 64'(hold[0]), 64'd1);
        idle(1);

        // 2: first word
        pulse_start(0);
        send_word(0, 32'h2008_0005, 0, 0);
        settle_check(0);
        check("t2_count", 64'(cnt0), 64'd1);
        check("t2_ready", 64'(ready[0]), 64'd1);

        // 3: two more words ending in the halt word, with exact done timing
        send_word(0, 32'h0000_0000, 0, 1);
        for (int i = 0; i < 4; i++) send_byte(0, 8'hFF);
        @(negedge clk);
        check("t3_we", 64'(we[0]), 64'd1);
        check("t3_wdata", 64'(wdata[0]), 64'(HALT));
        check("t3_done_early", 64'(done[0]), 64'd0);
        idle(1);
        @(negedge clk);
        check("t3_done", 64'(done[0]), 64'd1);
        check("t3_hold", 64'(hold[0]), 64'd0);
        idle(1);
        settle_check(0);
        check("t3_count", 64'(cnt0), 64'd3);
        check("t3_ovf", 64'(ovf[0]), 64'd0);
        bvalid[0] = 1'b1;
        bdata[0]  = 8'h55;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_no_consume", 64'(ready[0]), 64'd0);
        end
        idle(1);
        bvalid[0] = 1'b0;

        // 4: byte valid every third cycle
        pulse_start(0);
        send_word(0, 32'h8C01_0004, 2, 2);
        settle_check(0);
        check("t4_count", 64'(cnt0), 64'd1);

        // 5: small memory fills without a halt word
        pulse_start(1);
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            if (w == HALT) w = 32'h0;
            send_word(1, w, 0, 2);
        end
        settle_check(1);
        check("t5_done", 64'(done[1]), 64'd1);
        check("t5_ovf", 64'(ovf[1]), 64'd1);
        check("t5_count", 64'(cnt1), 64'd4);
        bvalid[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_consume", 64'(ready[1]), 64'd0);
        end
        idle(1);
        bvalid[1] = 1'b0;

        // 6: partial word discarded by reset, by restart, and a reset during WRITE
        pulse_start(0);
        send_byte(0, 8'hAA);
        send_byte(0, 8'hBB);
        pulse_reset();
        pulse_start(0);
        send_word(0, 32'h0102_0304, 0, 1);
        settle_check(0);
        check("t6_count", 64'(cnt0), 64'd1);
        pulse_start(0);
        send_byte(0, 8'hAA);
        send_byte(0, 8'hBB);
        pulse_start(0);
        send_word(0, 32'h0102_0304, 0, 0);
        settle_check(0);
        check("t6_restart_count", 64'(cnt0), 64'd1);
        pulse_start(0);
        send_word(0, 32'h1234_5678, 0, 0);
        reset = 1'b0;
        #1;
        check("t6_we_drop", 64'(we[0]), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1);

        // random loads on both instances
        for (int r = 0; r < 8; r++) begin
            k  = $urandom_range(0, 1);
            nw = $urandom_range(1, (k == 0) ? 6 : 5);
            pulse_start(k);
            for (int i = 0; i < nw; i++) begin
                if (!stopped[k]) begin
                    w = ($urandom_range(0, 3) == 0) ? HALT : $urandom;
                    send_word(k, w, 0, 2);
                end
            end
            settle_check(k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
